// File: rtl/rle_compressor.sv
// Serial run-length encoder: merges runs of equal input bits into {bit, len[6:0]}
// codewords, queues them in a small FIFO and re-serialises them MSB-first.
module rle_compressor #(
  parameter int MEM_ADR_LEN = 2
) (
  input  logic i_sclk,
  input  logic i_rst,
  input  logic i_serIn,
  input  logic i_bitValid,
  input  logic i_flush,
  output logic o_inReady,
  output logic o_stackFull,
  output logic o_serOut,
  output logic o_serValid,
  output logic o_busy
);

  localparam int DEPTH = 2 ** MEM_ADR_LEN;
  localparam logic [MEM_ADR_LEN-1:0] PTR_ONE = 1;
  localparam logic [MEM_ADR_LEN:0] CNT_ONE = 1;
  localparam logic [MEM_ADR_LEN:0] CNT_FULL = (MEM_ADR_LEN + 1)'(DEPTH);

  typedef enum logic {R_IDLE, R_RUN} runState_t;
  typedef enum logic {S_IDLE, S_SHIFT} serState_t;

  runState_t r_runState, w_runNext;
  logic r_curBit, w_curBitNext;
  logic [6:0] r_cnt, w_cntNext;

  logic [7:0] r_mem [DEPTH];
  logic [MEM_ADR_LEN-1:0] r_wrPtr, r_rdPtr;
  logic [MEM_ADR_LEN:0] r_count, w_countNext;
  logic r_stackFull;

  serState_t r_serState, w_serNext;
  logic [7:0] r_shreg, w_shregNext;
  logic [2:0] r_bitCnt, w_bitCntNext;

  logic w_accept, w_flushReq, w_push, w_pop;
  logic [7:0] w_pushData;

  // A flush waits for an idle input cycle with FIFO room, so at most one push per cycle.
  assign w_accept   = i_bitValid && !r_stackFull;
  assign w_flushReq = i_flush && !i_bitValid && !r_stackFull;

  always_comb begin
    w_runNext    = r_runState;
    w_curBitNext = r_curBit;
    w_cntNext    = r_cnt;
    w_push       = 1'b0;
    w_pushData   = 8'h00;
    case (r_runState)
      R_IDLE: begin
        if (w_accept) begin
          w_runNext    = R_RUN;
          w_curBitNext = i_serIn;
          w_cntNext    = 7'd1;
        end
      end
      R_RUN: begin
        if (w_accept) begin
          if (i_serIn == r_curBit) begin
            if (r_cnt == 7'd127) begin
              w_push     = 1'b1;
              w_pushData = {r_curBit, 7'd127};
              w_cntNext  = 7'd1;
            end else begin
              w_cntNext = r_cnt + 7'd1;
            end
          end else begin
            w_push       = 1'b1;
            w_pushData   = {r_curBit, r_cnt};
            w_curBitNext = i_serIn;
            w_cntNext    = 7'd1;
          end
        end else if (w_flushReq) begin
          w_push     = 1'b1;
          w_pushData = {r_curBit, r_cnt};
          w_runNext  = R_IDLE;
        end
      end
      default: w_runNext = R_IDLE;
    endcase
  end

  // The 8th shifted bit doubles as the reload point so consecutive codewords leave no gap.
  always_comb begin
    w_serNext     = r_serState;
    w_shregNext   = r_shreg;
    w_bitCntNext  = r_bitCnt;
    w_pop         = 1'b0;
    case (r_serState)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_shregNext  = r_mem[r_rdPtr];
          w_bitCntNext = 3'd0;
          w_serNext    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_bitCnt == 3'd7) begin
          if (r_count != '0) begin
            w_pop        = 1'b1;
            w_shregNext  = r_mem[r_rdPtr];
            w_bitCntNext = 3'd0;
          end else begin
            w_serNext = S_IDLE;
          end
        end else begin
          w_shregNext  = {r_shreg[6:0], 1'b0};
          w_bitCntNext = r_bitCnt + 3'd1;
        end
      end
      default: w_serNext = S_IDLE;
    endcase
  end

  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + CNT_ONE;
      2'b01:   w_countNext = r_count - CNT_ONE;
      default: w_countNext = r_count;
    endcase
  end

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      r_runState <= R_IDLE;
      r_curBit   <= 1'b0;
      r_cnt      <= 7'd0;
    end else begin
      r_runState <= w_runNext;
      r_curBit   <= w_curBitNext;
      r_cnt      <= w_cntNext;
    end
  end

  always_ff @(posedge i_sclk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= w_pushData;
    end
  end

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_stackFull <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      r_count     <= w_countNext;
      r_stackFull <= (w_countNext == CNT_FULL);
    end
  end

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      r_serState <= S_IDLE;
      r_shreg    <= 8'h00;
      r_bitCnt   <= 3'd0;
    end else begin
      r_serState <= w_serNext;
      r_shreg    <= w_shregNext;
      r_bitCnt   <= w_bitCntNext;
    end
  end

  assign o_inReady   = !r_stackFull;
  assign o_stackFull = r_stackFull;
  assign o_serValid  = (r_serState == S_SHIFT);
  assign o_serOut    = (r_serState == S_SHIFT) ? r_shreg[7] : 1'b0;
  assign o_busy      = (r_runState == R_RUN) || (r_count != '0) || (r_serState == S_SHIFT);

endmodule

// File: tb/tb_rle_compressor.sv
// Directed bench for rle_compressor: drives hand-built bit streams and checks the
// serial codeword stream, flow control and reset behaviour against fixed values.
module tb_rle_compressor;

  logic clk = 1'b0;
  logic rst, serIn, bitValid, flush;
  logic inReady, stackFull, serOut, serValid, busy;

  int checks = 0;
  int bad = 0;

  logic [7:0] rxQ [$];
  logic [7:0] rxShift = 8'h00;
  int rxCnt = 0;
  logic prevValid = 1'b0;
  int segments = 0;
  logic sawFull = 1'b0;

  int base;
  int seg;
  logic [15:0] pattern;

  rle_compressor #(.MEM_ADR_LEN(2)) dut (
    .i_sclk(clk),
    .i_rst(rst),
    .i_serIn(serIn),
    .i_bitValid(bitValid),
    .i_flush(flush),
    .o_inReady(inReady),
    .o_stackFull(stackFull),
    .o_serOut(serOut),
    .o_serValid(serValid),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Reassemble codewords from the serial output and note every start of a serValid burst.
  always @(negedge clk) begin
    if (rst) begin
      rxCnt = 0;
      prevValid = 1'b0;
    end else begin
      if (serValid) begin
        rxShift = {rxShift[6:0], serOut};
        rxCnt++;
        if (rxCnt == 8) begin
          rxQ.push_back(rxShift);
          rxCnt = 0;
        end
        if (!prevValid) segments++;
      end
      prevValid = serValid;
      if (stackFull && !inReady) sawFull = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one bit and holds it through any stall until it is accepted.
  task automatic applyStimulus(input logic b);
    int n;
    serIn = b;
    bitValid = 1'b1;
    n = 0;
    while (!inReady && n < 100) begin
      tick();
      n++;
    end
    checkOutput("accept_ready", 32'(inReady), 32'd1);
    tick();
    bitValid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    checkOutput("idle_reached", 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    serIn = 1'b0;
    bitValid = 1'b0;
    flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("rst_serOut", 32'(serOut), 32'd0);
    checkOutput("rst_serValid", 32'(serValid), 32'd0);
    checkOutput("rst_stackFull", 32'(stackFull), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_inReady", 32'(inReady), 32'd1);

    // Basic runs 1,1,1,0,0 + flush -> 0x83, 0x02 as one contiguous 16-bit burst.
    base = rxQ.size();
    seg = segments;
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("basic_first_valid", 32'(serValid), 32'd1);
    checkOutput("basic_first_msb", 32'(serOut), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pattern = 16'h8302;
    for (int i = 0; i < 15; i++) begin
      checkOutput($sformatf("basic_valid%0d", i), 32'(serValid), 32'd1);
      checkOutput($sformatf("basic_bit%0d", i), 32'(serOut), 32'(pattern[14 - i]));
      tick();
    end
    checkOutput("basic_end_valid", 32'(serValid), 32'd0);
    checkOutput("basic_end_busy", 32'(busy), 32'd0);
    checkOutput("basic_count", rxQ.size() - base, 32'd2);
    checkOutput("basic_word0", 32'(rxQ[base]), 32'h83);
    checkOutput("basic_word1", 32'(rxQ[base + 1]), 32'h02);
    checkOutput("basic_bursts", segments - seg, 32'd1);

    // Runs longer than 127 split into a full codeword plus remainder.
    base = rxQ.size();
    for (int i = 0; i < 130; i++) applyStimulus(1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    waitIdle();
    checkOutput("split1_count", rxQ.size() - base, 32'd2);
    checkOutput("split1_word0", 32'(rxQ[base]), 32'hFF);
    checkOutput("split1_word1", 32'(rxQ[base + 1]), 32'h83);
    base = rxQ.size();
    for (int i = 0; i < 129; i++) applyStimulus(1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    waitIdle();
    checkOutput("split0_count", rxQ.size() - base, 32'd2);
    checkOutput("split0_word0", 32'(rxQ[base]), 32'h7F);
    checkOutput("split0_word1", 32'(rxQ[base + 1]), 32'h02);

    // Alternating bits fill the FIFO; stalled bits and a deferred flush must not be lost.
    base = rxQ.size();
    seg = segments;
    for (int i = 0; i < 12; i++) applyStimulus(logic'(i % 2));
    checkOutput("full_after_last", 32'(stackFull), 32'd1);
    checkOutput("full_inReady", 32'(inReady), 32'd0);
    flush = 1'b1;
    tick();
    checkOutput("full_flush_deferred", 32'(stackFull), 32'd1);
    for (int i = 0; i < 20; i++) tick();
    flush = 1'b0;
    waitIdle();
    checkOutput("full_seen", 32'(sawFull), 32'd1);
    checkOutput("full_count", rxQ.size() - base, 32'd12);
    for (int k = 0; k < 12; k++) begin
      checkOutput($sformatf("full_word%0d", k), 32'(rxQ[base + k]), (k % 2 == 0) ? 32'h01 : 32'h81);
    end
    checkOutput("full_bursts", segments - seg, 32'd1);

    // Flush together with a valid bit is deferred, so the bit joins the run.
    base = rxQ.size();
    serIn = 1'b1;
    bitValid = 1'b1;
    flush = 1'b1;
    tick();
    tick();
    bitValid = 1'b0;
    tick();
    flush = 1'b0;
    waitIdle();
    checkOutput("flushvalid_count", rxQ.size() - base, 32'd1);
    checkOutput("flushvalid_word", 32'(rxQ[base]), 32'h82);

    // Flush with no open run emits nothing.
    base = rxQ.size();
    flush = 1'b1;
    tick();
    tick();
    tick();
    flush = 1'b0;
    checkOutput("flushidle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("flushidle_valid", 32'(serValid), 32'd0);
    checkOutput("flushidle_count", rxQ.size() - base, 32'd0);

    // Reset during the 4th bit of 0x83 with two codewords queued discards everything.
    base = rxQ.size();
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    tick();
    checkOutput("midrst_shifting", 32'(serValid), 32'd1);
    checkOutput("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("midrst_serValid", 32'(serValid), 32'd0);
    checkOutput("midrst_serOut", 32'(serOut), 32'd0);
    checkOutput("midrst_stackFull", 32'(stackFull), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_inReady", 32'(inReady), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checkOutput("midrst_nothing_out", rxQ.size() - base, 32'd0);
    checkOutput("midrst_still_idle", 32'(busy), 32'd0);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    waitIdle();
    checkOutput("postrst_count", rxQ.size() - base, 32'd2);
    checkOutput("postrst_word0", 32'(rxQ[base]), 32'h03);
    checkOutput("postrst_word1", 32'(rxQ[base + 1]), 32'h81);

    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
